// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle unsigned adder.
// Adds two WIDTH-bit operands DIGIT bits per clock, least significant digit
// first, with a registered carry between digits. The result appears
// STEPS = WIDTH/DIGIT clocks after the operands are accepted. Only one
// operation is in flight at a time.
// Valid/ready handshakes are used on both the operand side and the result side.
// Optional feature: define SEQ_DIGIT_ADDER_SUB_EN to add the sub_i port.
// When the latched sub_i is 1, the block computes a - b. B is inverted as
// each digit is consumed, and the carry starts at 1.
`default_nettype none

module seq_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   sum_o,
  output logic             busy_o
);

  // Number of RUN cycles; guarded so an illegal DIGIT cannot divide by zero
  // before the parameter check below reports it.
  localparam int STEPS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  // Refuse to elaborate with a digit size that does not tile the operand.
  localparam bit PARAM_BAD = (WIDTH < 1) ? 1'b1 :
                             (DIGIT < 1) ? 1'b1 :
                             (DIGIT > WIDTH) ? 1'b1 :
                             ((WIDTH % DIGIT) != 0);
  generate
    if (PARAM_BAD) begin : g_param_check
      $error("seq_digit_adder: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   part_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH:0]     sum_reg;
  logic               out_valid_reg;

`ifdef SEQ_DIGIT_ADDER_SUB_EN
  logic               sub_reg;
`endif

  // Digit adder: a DIGIT-bit ripple chain fed by the registered carry.
  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [DIGIT-1:0]   d_dig;
  logic [DIGIT:0]     c_chain;
  logic               c_out;

  assign a_dig = a_reg[DIGIT-1:0];
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: B is inverted digit by digit as it is consumed.
  assign b_dig = sub_reg ? ~b_reg[DIGIT-1:0] : b_reg[DIGIT-1:0];
`else
  assign b_dig = b_reg[DIGIT-1:0];
`endif
  assign c_chain[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi = gi + 1) begin : g_digit_bit
      assign d_dig[gi]     = a_dig[gi] ^ b_dig[gi] ^ c_chain[gi];
      assign c_chain[gi+1] = (a_dig[gi] & b_dig[gi]) |
                             (c_chain[gi] & (a_dig[gi] ^ b_dig[gi]));
    end
  endgenerate

  assign c_out = c_chain[DIGIT];

  // The new digit enters at the top of the partial sum. After STEPS shifts,
  // the first digit has reached bit 0. Concatenating before slicing keeps
  // this legal when DIGIT == WIDTH.
  logic [WIDTH+DIGIT-1:0] part_wide;
  logic [WIDTH-1:0]       part_next;

  assign part_wide = {d_dig, part_reg};
  assign part_next = part_wide[WIDTH+DIGIT-1:DIGIT];

  logic last_step;
  assign last_step = (count_reg == LAST_STEP);

  // Carry value loaded at acceptance: 1 starts a two's-complement subtract.
  logic carry_init;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  assign carry_init = sub_i;
`else
  assign carry_init = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs. in_ready is masked during reset
  // so no upstream transfer can complete while the block is being cleared.
  always_comb begin
    state_next = state_reg;
    in_ready_o = 1'b0;
    busy_o     = 1'b1;
    case (state_reg)
      IDLE: begin
        busy_o     = 1'b0;
        in_ready_o = !rst_i;
        if (in_valid_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy_o     = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, digit-serial add, and result/valid holding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_reg         <= '0;
      b_reg         <= '0;
      part_reg      <= '0;
      carry_reg     <= 1'b0;
      count_reg     <= '0;
      sum_reg       <= '0;
      out_valid_reg <= 1'b0;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            a_reg     <= a_i;
            b_reg     <= b_i;
            part_reg  <= '0;
            carry_reg <= carry_init;
            count_reg <= '0;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
            sub_reg   <= sub_i;
`endif
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          part_reg  <= part_next;
          carry_reg <= c_out;
          count_reg <= count_reg + 1'b1;
          if (last_step) begin
            sum_reg       <= {c_out, part_next};
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_reg;
  assign sum_o       = sum_reg;

endmodule

`default_nettype wire

// File: tb/tb_seq_digit_adder.sv
// Testbench for seq_digit_adder. Two instances are tested: WIDTH=8 with
// DIGIT=2, and WIDTH=8 with DIGIT=8. A transaction-level model predicts the
// results and handshake outputs, and is checked every cycle. Directed
// literal expectations check the latency and result values.
// Define SEQ_DIGIT_ADDER_SUB_EN to also run the subtract vectors.
`timescale 1ns/1ps

module tb_seq_digit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid[2];
  logic       out_ready[2];
  logic       in_ready[2];
  logic       out_valid[2];
  logic       busy[2];
  logic [7:0] a[2];
  logic [7:0] b[2];
  logic       sub[2];
  logic [8:0] sum[2];

  seq_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .a_i(a[0]), .b_i(b[0]),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    .sub_i(sub[0]),
`endif
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .sum_o(sum[0]), .busy_o(busy[0])
  );

  seq_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .a_i(a[1]), .b_i(b[1]),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    .sub_i(sub[1]),
`endif
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .sum_o(sum[1]), .busy_o(busy[1])
  );

  // ---------------- behavioural model ----------------
  // Phase 0 means waiting for operands. Phase 1 means a result is due after
  // m_left more clocks. Phase 2 means a result is offered.
  int         m_phase[2];
  int         m_left[2];
  logic       m_valid[2];
  logic [8:0] m_pend[2];
  logic [8:0] m_sum[2];

  function automatic logic [8:0] expect_result(logic [7:0] x, logic [7:0] y, logic s);
    logic [8:0] r;
    if (s) begin
      r[8]   = (x >= y);
      r[7:0] = x - y;
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  function automatic int steps_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] <= 0;
        m_left[i]  <= 0;
        m_valid[i] <= 1'b0;
        m_sum[i]   <= '0;
      end else begin
        case (m_phase[i])
          0: if (in_valid[i]) begin
               m_phase[i] <= 1;
               m_left[i]  <= steps_of(i);
               m_pend[i]  <= expect_result(a[i], b[i], sub[i]);
             end
          1: if (m_left[i] == 1) begin
               m_phase[i] <= 2;
               m_valid[i] <= 1'b1;
               m_sum[i]   <= m_pend[i];
             end else begin
               m_left[i] <= m_left[i] - 1;
             end
          default: if (out_ready[i]) begin
               m_phase[i] <= 0;
               m_valid[i] <= 1'b0;
             end
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    string       name;
    logic [15:0] got;
    logic [15:0] exp;
  } lit_t;

  lit_t lit_q[$];
  int   lit_idx  = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // The only process that compares: it handles the queued directed
  // expectations, then the per-cycle model comparison.
  always @(negedge clk) begin
    while (lit_idx < lit_q.size()) begin
      check(lit_q[lit_idx].name, lit_q[lit_idx].got, lit_q[lit_idx].exp);
      lit_idx++;
    end
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.in_ready", i), 16'(in_ready[i]),
              16'((m_phase[i] == 0) && !rst));
        check($sformatf("u%0d.busy", i), 16'(busy[i]), 16'(m_phase[i] != 0));
        check($sformatf("u%0d.out_valid", i), 16'(out_valid[i]), 16'(m_valid[i]));
        check($sformatf("u%0d.sum", i), 16'(sum[i]), 16'(m_sum[i]));
      end
    end
  end

  task automatic lit(string n, logic [15:0] g, logic [15:0] e);
    lit_q.push_back('{n, g, e});
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance i. The result is held for `hold`
  // cycles before it is released. If `poke` is set, a new request is
  // presented during the hold and must be ignored.
  task automatic run_op(int i, logic [7:0] x, logic [7:0] y, logic s,
                        logic [8:0] exp_sum, int exp_lat, int hold, bit poke,
                        string tag);
    int cnt;
    bit ready_seen;
    logic [8:0] first;
    in_valid[i]  = 1'b1;
    a[i]         = x;
    b[i]         = y;
    sub[i]       = s;
    out_ready[i] = 1'b0;
    lit({tag, "_ready_idle"}, 16'(in_ready[i]), 16'd1);
    step();
    in_valid[i] = 1'b0;
    a[i]        = ~x;
    b[i]        = ~y;
    cnt         = 0;
    ready_seen  = 1'b0;
    while (!out_valid[i] && cnt < 20) begin
      if (in_ready[i]) ready_seen = 1'b1;
      step();
      cnt++;
    end
    lit({tag, "_latency"}, 16'(cnt), 16'(exp_lat));
    lit({tag, "_sum"}, 16'(sum[i]), 16'(exp_sum));
    lit({tag, "_ready_run"}, 16'(ready_seen), 16'd0);
    first = sum[i];
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid[i] = 1'b1;
        a[i]        = 8'h11;
        b[i]        = 8'h22;
      end
      step();
      lit({tag, "_hold_sum"}, 16'(sum[i]), 16'(first));
      lit({tag, "_hold_valid"}, 16'(out_valid[i]), 16'd1);
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    step();
    out_ready[i] = 1'b0;
    lit({tag, "_valid_drop"}, 16'(out_valid[i]), 16'd0);
    lit({tag, "_ready_back"}, 16'(in_ready[i]), 16'd1);
    lit({tag, "_sum_kept"}, 16'(sum[i]), 16'(exp_sum));
    $display("txn %s: a=%h b=%h sub=%0d sum=%h latency=%0d", tag, x, y, s, first, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a[i]         = '0;
      b[i]         = '0;
      sub[i]       = 1'b0;
    end
    step();
    step();
    lit("reset_ready_low", 16'(in_ready[0]), 16'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    #1;
    lit("reset_sum", 16'(sum[0]), 16'h000);
    lit("reset_valid", 16'(out_valid[0]), 16'd0);
    lit("reset_busy", 16'(busy[0]), 16'd0);
    lit("reset_ready", 16'(in_ready[0]), 16'd1);
    step();

    // Carry ripples through every digit.
    run_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, 4, 0, 1'b0, "ff_plus_01");
    // Result held while downstream stalls; new request ignored.
    run_op(0, 8'h0F, 8'h0A, 1'b0, 9'h019, 4, 3, 1'b1, "stall");
    run_op(0, 8'hFF, 8'hFF, 1'b0, 9'h1FE, 4, 1, 1'b0, "max");
    run_op(0, 8'h00, 8'h00, 1'b0, 9'h000, 4, 0, 1'b0, "zero");
    // Single-step instance.
    run_op(1, 8'hAA, 8'h55, 1'b0, 9'h0FF, 1, 0, 1'b0, "d8_aa55");
    run_op(1, 8'hFF, 8'hFF, 1'b0, 9'h1FE, 1, 2, 1'b1, "d8_max");

    // Back-to-back requests with in_valid held high.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    a[0] = 8'h80;
    b[0] = 8'h80;
    step();
    a[0] = 8'h00;
    b[0] = 8'h00;
    cnt = 0;
    while (!out_valid[0] && cnt < 20) begin step(); cnt++; end
    lit("stream_lat1", 16'(cnt), 16'd4);
    lit("stream_sum1", 16'(sum[0]), 16'h100);
    step();
    lit("stream_idle_gap", 16'(busy[0]), 16'd0);
    step();
    in_valid[0] = 1'b0;
    lit("stream_accept2", 16'(busy[0]), 16'd1);
    cnt = 0;
    while (!out_valid[0] && cnt < 20) begin step(); cnt++; end
    lit("stream_lat2", 16'(cnt), 16'd4);
    lit("stream_sum2", 16'(sum[0]), 16'h000);
    step();
    out_ready[0] = 1'b0;
    $display("txn stream: 80+80 then 00+00");

    // Reset on the second RUN clock discards the operation.
    in_valid[0] = 1'b1;
    a[0] = 8'h03;
    b[0] = 8'h04;
    step();
    in_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    lit("midrst_valid", 16'(out_valid[0]), 16'd0);
    lit("midrst_busy", 16'(busy[0]), 16'd0);
    lit("midrst_ready_in_rst", 16'(in_ready[0]), 16'd0);
    rst = 1'b0;
    #1;
    lit("midrst_ready_after", 16'(in_ready[0]), 16'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid[0]) seen++;
    end
    lit("midrst_no_result", 16'(seen), 16'd0);
    $display("txn midrst: operation discarded");

`ifdef SEQ_DIGIT_ADDER_SUB_EN
    run_op(0, 8'h05, 8'h07, 1'b1, 9'h0FE, 4, 0, 1'b0, "sub_5_7");
    run_op(0, 8'h07, 8'h05, 1'b1, 9'h102, 4, 0, 1'b0, "sub_7_5");
    run_op(0, 8'h40, 8'h40, 1'b1, 9'h100, 4, 0, 1'b0, "sub_eq");
    run_op(1, 8'h05, 8'h07, 1'b1, 9'h0FE, 1, 0, 1'b0, "d8_sub_5_7");
`endif

    step();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_digit_adder.md
Name: seq_digit_adder

Overview:
- Parametrised multi-cycle unsigned adder; successor to the fixed 4-bit combinational adder.
- Adds two WIDTH-bit operands DIGIT bits per clock with a registered ripple carry, trading latency for a narrow carry chain.
- Valid/ready handshakes on input and output so it can sit between pipelined lab datapath stages.
- One operation in flight at a time.

Parameters:
- WIDTH, default 8: operand width in bits; must be at least 1.
- DIGIT, default 2: bits added per clock; 1 <= DIGIT <= WIDTH, and WIDTH % DIGIT == 0.
- STEPS, derived (not overridable) = WIDTH/DIGIT: number of RUN cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  operands a_i/b_i are valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  WIDTH  operand A, unsigned.
- b_i  in  WIDTH  operand B, unsigned.
- out_valid_o  out  1  sum_o holds a completed result.
- out_ready_i  in  1  downstream accepts the result.
- sum_o  out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state=IDLE, out_valid_o=0, sum_o=0, busy_o=0, internal carry/count/shift registers=0.
  - in_ready_o is forced to 0 while rst_i is high; all handshakes are ignored while rst_i is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i && in_ready_o: latch a_i and b_i into shift registers, carry=0, count=0, go to RUN.
- RUN:
  - in_ready_o=0.
  - Each edge: {c, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - d shifts into the top of the partial-sum register; carry <= c.
  - A and B shift right by DIGIT; count increments.
  - On the edge where count == STEPS-1: load sum_o with {c, final partial sum}, set out_valid_o=1, go to DONE.
- DONE:
  - out_valid_o=1; sum_o held stable; in_ready_o=0; in_valid_i is ignored.
  - On an edge with out_ready_i=1: out_valid_o<=0, go to IDLE.
- Latency: out_valid_o rises exactly STEPS clocks after the input-acceptance edge.
- Throughput: at most one result per STEPS+2 clocks (no overlap of output hold and new accept).
- sum_o changes only on the RUN->DONE edge or on reset; it holds the last result while in IDLE.
- Arithmetic:
  - Result = a + b modulo 2^(WIDTH+1), i.e. exact; no overflow is possible.
  - Operands are sampled only at acceptance, so changes on a_i/b_i afterwards have no effect.
- STEPS == 1 (DIGIT == WIDTH): one RUN cycle; out_valid_o high 1 clock after acceptance.
- Reset mid-operation (RUN or DONE): operation discarded, no output handshake produced, state returns to IDLE.
- Illegal parameters (WIDTH % DIGIT != 0, DIGIT == 0, or DIGIT > WIDTH): elaboration must fail with an error.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: SEQ_DIGIT_ADDER_SUB_EN.
- Defined:
  - Adds input port sub_i (1 bit), latched at acceptance.
  - When the latched sub_i is 1: B is inverted as it is consumed and carry initialises to 1.
  - sum_o = {carry_out, (a-b) mod 2^WIDTH}; carry_out=1 iff a >= b.
  - Latency is unchanged.
- Undefined: sub_i port absent; add only; carry initialises to 0.

Test Plan:
- WIDTH=8, DIGIT=2: reset, then accept a=8'hFF, b=8'h01 -> out_valid_o rises 4 clocks after acceptance with sum_o=9'h100; in_ready_o=0 throughout.
- a=8'h0F, b=8'h0A, out_ready_i held low for 3 clocks in DONE -> sum_o=9'h019 stays stable, out_valid_o stays 1, a new in_valid_i pulse is not accepted; out_ready_i=1 -> IDLE the next clock.
- in_valid_i held high with (8'h80, 8'h80) followed by (8'h00, 8'h00) -> results 9'h100 then 9'h000; the second operand set is accepted only after the first output handshake.
- rst_i asserted on the 2nd RUN clock -> the next clock shows out_valid_o=0 and busy_o=0, with in_ready_o=1 once rst_i deasserts; no result is emitted.
- WIDTH=8, DIGIT=8 instance: a=8'hAA, b=8'h55 -> sum_o=9'h0FF, out_valid_o 1 clock after acceptance.
- SEQ_DIGIT_ADDER_SUB_EN defined, sub_i=1: a=5, b=7 -> sum_o=9'h0FE; a=7, b=5 -> sum_o=9'h102.
